traffic_light_ctrl: RTL and testbench
=====================================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter GREEN_CYC SHALL be: default 20, green duration in clk cycles.
REQ-002 Parameter YELLOW_CYC SHALL be: default 5, yellow duration in cycles.
REQ-003 Parameter ALLRED_CYC SHALL be: default 2, all-red clearance duration in cycles.
REQ-004 Parameter WALK_CYC SHALL be: default 10, pedestrian walk duration in cycles.
REQ-005 Parameter FLASH_HALF SHALL be: default 4, half-period of flash blink in cycles.
REQ-006 Parameter TW SHALL be: default 16, phase-timer width in bits.
REQ-007 Port clk SHALL be: input, 1, sole clock, rising edge.
REQ-008 Port rst SHALL be: input, 1, synchronous active-high reset.
REQ-009 Port en SHALL be: input, 1, timer/sequence advance enable.
REQ-010 Port flash_mode SHALL be: input, 1, night mode request (all-yellow blink).
REQ-011 Port ped_req SHALL be: input, 1, pedestrian request, level or single-cycle pulse.
REQ-012 Ports N, S, E, W SHALL each be: output, 3, lamp code: 001 green, 010 yellow, 100 red, 000 dark.
REQ-013 Port walk SHALL be: output, 1, pedestrian walk lamp.
REQ-014 Port phase SHALL be: output, 2, active approach index: 0=S, 1=W, 2=N, 3=E.

Function
REQ-015 States SHALL be GREEN, YELLOW, ALLRED, WALK, FLASH; all outputs decode from registered state, dir and blink only, with no combinational path from inputs.
REQ-016 Each timed state SHALL last exactly its parameter count of enabled cycles: timer cleared on entry, exit on the edge where timer == PARAM-1 and en=1.
REQ-017 en=0 SHALL freeze timer, state, dir and blink; ped_pending capture SHALL continue.
REQ-018 GREEN SHALL drive approach dir 001 and the others 100, then go to YELLOW.
REQ-019 YELLOW SHALL drive approach dir 010 and the others 100, then go to ALLRED.
REQ-020 ALLRED SHALL drive all four 100 and, on exit, go to WALK if ped_pending=1, else to GREEN with dir = dir+1 mod 4.
REQ-021 WALK SHALL drive all four 100 with walk=1, then go to GREEN with dir = dir+1 mod 4; walk SHALL be 0 in every other state.
REQ-022 ped_pending SHALL set on any cycle with ped_req=1 outside WALK, ignore ped_req during WALK, and clear on the WALK-entry edge, with clear taking priority over a same-cycle set.
REQ-023 flash_mode=1 SHALL force FLASH on the next edge from any state, regardless of en.
REQ-024 FLASH SHALL set blink=1 on entry, toggle blink every FLASH_HALF cycles, drive all four 010 when blink=1 and 000 when blink=0, hold walk=0, and clear ped_pending.
REQ-025 flash_mode falling SHALL move FLASH to ALLRED with dir=3, so the next green is S.
REQ-026 phase SHALL equal dir at all times.
REQ-027 All cycle parameters SHALL be >=1 and <2^TW; the timer SHALL never wrap within a state.

Reset
REQ-028 rst=1 SHALL on the next edge set state=ALLRED, dir=3, timer=0, blink=0, ped_pending=0, N=S=E=W=100, walk=0, phase=3.
REQ-029 rst SHALL take priority over flash_mode, en and ped_req, including mid-WALK and mid-FLASH.
REQ-030 After rst release with en=1, the first GREEN (S) SHALL begin ALLRED_CYC cycles later.

Verification
REQ-031 The bench SHALL cover this sequence: defaults, rst then en=1 -> all 100 for 2 cycles; S=001 for 20; S=010 for 5; all 100 for 2; W=001, phase=1.
REQ-032 The bench SHALL cover this sequence: 1-cycle ped_req during S green -> S yellow 5, all-red 2, walk=1 with all 100 for 10, then W green; a second ped_req during walk is ignored.
REQ-033 The bench SHALL cover this sequence: en=0 for 7 cycles mid S-green -> S=001 persists 27 cycles total; a ped_req pulse while en=0 is still honoured.
REQ-034 The bench SHALL cover this sequence: flash_mode=1 mid-yellow -> next cycle all 010 for 4, 000 for 4, repeating; flash_mode=0 -> all 100 for 2, then S=001.
REQ-035 The bench SHALL cover this sequence: full rotation -> E green (phase 3) -> yellow -> all-red -> S green, phase 3->0 wrap.
REQ-036 The bench SHALL cover this sequence: rst=1 mid-WALK -> next edge walk=0, all 100, phase=3, pending cleared, and no walk after release.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_light_ctrl
//
// Four-approach intersection controller. Approaches are served in the order
// S -> W -> N -> E. Each approach gets GREEN, then YELLOW, then an all-red
// clearance. A pending pedestrian request inserts a WALK interval, with all
// approaches red, after the clearance. Night mode (flash_mode) blinks all
// approaches yellow. Leaving night mode goes through all-red with dir=3, so
// the next green is S.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (priority over all inputs)
//   en           advance enable; 0 freezes timer/state/dir/blink
//   flash_mode   night-mode request (all-yellow blink)
//   ped_req      pedestrian request, level or single-cycle pulse
//   N, S, E, W   lamp codes: 001 green, 010 yellow, 100 red, 000 dark
//   walk         pedestrian walk lamp
//   phase        active approach index: 0=S, 1=W, 2=N, 3=E
//
// All outputs are registers. They are loaded from the decode of the
// next-state values, so they always match the registered state, dir and
// blink. No input reaches an output combinationally.
//
// Every cycle parameter must be >= 1 and < 2**TW. Under that condition the
// timer never wraps within a state.
// ---------------------------------------------------------------------------
module traffic_light_ctrl #(
  parameter int GREEN_CYC  = 20,
  parameter int YELLOW_CYC = 5,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 10,
  parameter int FLASH_HALF = 4,
  parameter int TW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flash_mode,
  input  logic       ped_req,
  output logic [2:0] N,
  output logic [2:0] S,
  output logic [2:0] E,
  output logic [2:0] W,
  output logic       walk,
  output logic [1:0] phase
);

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_ALLRED = 3'd2,
    ST_WALK   = 3'd3,
    ST_FLASH  = 3'd4
  } state_t;

  localparam logic [2:0] LAMP_GRN  = 3'b001;
  localparam logic [2:0] LAMP_YEL  = 3'b010;
  localparam logic [2:0] LAMP_RED  = 3'b100;
  localparam logic [2:0] LAMP_DARK = 3'b000;

  // Approach indices, matching the phase encoding.
  localparam logic [1:0] DIR_S = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_N = 2'd2;
  localparam logic [1:0] DIR_E = 2'd3;

  state_t        state, state_nxt;
  logic [1:0]    dir, dir_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          blink, blink_nxt;
  logic          ped_pending, pend_nxt;
  logic          at_last;

  // Timer value on the final cycle of a timed state. In FLASH this is the
  // final cycle of one blink half-period.
  function automatic logic [TW-1:0] last_count(input state_t s);
    logic [TW-1:0] r;
    case (s)
      ST_GREEN:  r = TW'(GREEN_CYC - 1);
      ST_YELLOW: r = TW'(YELLOW_CYC - 1);
      ST_ALLRED: r = TW'(ALLRED_CYC - 1);
      ST_WALK:   r = TW'(WALK_CYC - 1);
      ST_FLASH:  r = TW'(FLASH_HALF - 1);
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Lamp decode, returned as {N, S, E, W}.
  function automatic logic [11:0] lamp_decode(input state_t s,
                                              input logic [1:0] d,
                                              input logic b);
    logic [2:0] act;
    logic [2:0] ln, ls, le, lw;
    act = LAMP_RED;
    if (s == ST_GREEN)  act = LAMP_GRN;
    if (s == ST_YELLOW) act = LAMP_YEL;
    ls = (d == DIR_S) ? act : LAMP_RED;
    lw = (d == DIR_W) ? act : LAMP_RED;
    ln = (d == DIR_N) ? act : LAMP_RED;
    le = (d == DIR_E) ? act : LAMP_RED;
    if (s == ST_FLASH) begin
      ls = b ? LAMP_YEL : LAMP_DARK;
      lw = ls;
      ln = ls;
      le = ls;
    end
    return {ln, ls, le, lw};
  endfunction

  assign at_last = (timer == last_count(state));

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = timer;
    blink_nxt = blink;
    // Capture runs even while en=0. Requests made during WALK are dropped,
    // because that walk is already serving them.
    pend_nxt  = ped_pending | (ped_req && (state != ST_WALK));

    if ((state != ST_FLASH) && flash_mode) begin
      // Night mode overrides the sequence immediately, even when en=0.
      state_nxt = ST_FLASH;
      timer_nxt = '0;
      blink_nxt = 1'b1;
      pend_nxt  = 1'b0;
    end else if (state == ST_FLASH) begin
      pend_nxt = 1'b0;
      if (!flash_mode) begin
        // Exit mirrors entry and does not wait for en. Starting from dir=3
        // makes the first green after clearance S.
        state_nxt = ST_ALLRED;
        dir_nxt   = DIR_E;
        timer_nxt = '0;
        blink_nxt = 1'b0;
      end else if (en) begin
        if (at_last) begin
          timer_nxt = '0;
          blink_nxt = ~blink;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
    end else if (en) begin
      if (at_last) begin
        timer_nxt = '0;
        case (state)
          ST_GREEN:  state_nxt = ST_YELLOW;
          ST_YELLOW: state_nxt = ST_ALLRED;
          ST_ALLRED: begin
            if (ped_pending) begin
              state_nxt = ST_WALK;
              // Clearing on WALK entry wins over a request in the same cycle.
              pend_nxt  = 1'b0;
            end else begin
              state_nxt = ST_GREEN;
              dir_nxt   = dir + 2'd1;
            end
          end
          ST_WALK: begin
            state_nxt = ST_GREEN;
            dir_nxt   = dir + 2'd1;
          end
          default:   state_nxt = ST_ALLRED;
        endcase
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ALLRED;
      dir         <= DIR_E;
      timer       <= '0;
      blink       <= 1'b0;
      ped_pending <= 1'b0;
      N           <= LAMP_RED;
      S           <= LAMP_RED;
      E           <= LAMP_RED;
      W           <= LAMP_RED;
      walk        <= 1'b0;
      phase       <= DIR_E;
    end else begin
      state        <= state_nxt;
      dir          <= dir_nxt;
      timer        <= timer_nxt;
      blink        <= blink_nxt;
      ped_pending  <= pend_nxt;
      {N, S, E, W} <= lamp_decode(state_nxt, dir_nxt, blink_nxt);
      walk         <= (state_nxt == ST_WALK);
      phase        <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed test of traffic_light_ctrl with its default parameters.
// The stimulus process pushes the hand-derived expected output for each
// clock edge onto a queue. The monitor process pops one entry at every
// falling edge and compares it against the DUT outputs.
module tb_traffic_light_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       flash_mode;
  logic       ped_req;
  logic [2:0] N, S, E, W;
  logic       walk;
  logic [1:0] phase;

  traffic_light_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .flash_mode (flash_mode),
    .ped_req    (ped_req),
    .N          (N),
    .S          (S),
    .E          (E),
    .W          (W),
    .walk       (walk),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] DK = 3'b000;

  // Expected vector layout: {N, S, E, W, walk, phase}.
  logic [14:0] exq[$];
  string       tagq[$];
  logic        stim_done;
  int          total;
  int          bad;
  int          cyc;

  function automatic logic [14:0] vec(input logic [2:0] cs, input logic [2:0] cw,
                                      input logic [2:0] cn, input logic [2:0] ce,
                                      input logic wk, input logic [1:0] ph);
    return {cn, cs, ce, cw, wk, ph};
  endfunction

  // Lamp c on approach d, red elsewhere. phase equals d.
  function automatic logic [14:0] on(input logic [2:0] c, input logic [1:0] d);
    return vec((d == 2'd0) ? c : R, (d == 2'd1) ? c : R,
               (d == 2'd2) ? c : R, (d == 2'd3) ? c : R, 1'b0, d);
  endfunction

  function automatic logic [14:0] red(input logic [1:0] ph);
    return vec(R, R, R, R, 1'b0, ph);
  endfunction

  function automatic logic [14:0] wlk(input logic [1:0] ph);
    return vec(R, R, R, R, 1'b1, ph);
  endfunction

  function automatic logic [14:0] fl(input logic [2:0] c, input logic [1:0] ph);
    return vec(c, c, c, c, 1'b0, ph);
  endfunction

  // Queue the expected output after the next rising edge, then move past
  // that edge.
  task automatic step(input logic [14:0] e, input string tag);
    exq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic [14:0] e, input int n, input string tag);
    for (int i = 0; i < n; i++) step(e, tag);
  endtask

  // Reset, then release with en=1. Leaves the DUT one edge away from S green.
  task automatic do_reset(input string tag);
    rst = 1'b1; en = 1'b0; flash_mode = 1'b0; ped_req = 1'b0;
    seg(red(2'd3), 2, {tag, "_rst"});
    rst = 1'b0; en = 1'b1;
    step(red(2'd3), {tag, "_rel_allred"});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [14:0] exp_v;
    logic [14:0] got_v;
    string       t;
    cyc = cyc + 1;
    if (exq.size() > 0) begin
      exp_v = exq.pop_front();
      t     = tagq.pop_front();
      got_v = {N, S, E, W, walk, phase};
      total = total + 1;
      if (got_v !== exp_v) begin
        bad = bad + 1;
        $display("FAIL %s @%0t: got N=%b S=%b E=%b W=%b walk=%b phase=%0d, want N=%b S=%b E=%b W=%b walk=%b phase=%0d",
                 t, $time, got_v[14:12], got_v[11:9], got_v[8:6], got_v[5:3], got_v[2], got_v[1:0],
                 exp_v[14:12], exp_v[11:9], exp_v[8:6], exp_v[5:3], exp_v[2], exp_v[1:0]);
      end
    end
    if (cyc > 5000) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL watchdog: got cycle=%0d, want completion within 5000 cycles", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end else if (stim_done && exq.size() == 0) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    total = 0; bad = 0; cyc = 0; stim_done = 1'b0;
    rst = 1'b1; en = 1'b0; flash_mode = 1'b0; ped_req = 1'b0;

    // Basic cycle, then a full rotation with the phase 3 -> 0 wrap.
    do_reset("t1");
    seg(on(G, 2'd0), 20, "t1_s_green");
    seg(on(Y, 2'd0), 5,  "t1_s_yellow");
    seg(red(2'd0),   2,  "t1_s_allred");
    seg(on(G, 2'd1), 20, "t1_w_green");
    seg(on(Y, 2'd1), 5,  "t1_w_yellow");
    seg(red(2'd1),   2,  "t1_w_allred");
    seg(on(G, 2'd2), 20, "t1_n_green");
    seg(on(Y, 2'd2), 5,  "t1_n_yellow");
    seg(red(2'd2),   2,  "t1_n_allred");
    seg(on(G, 2'd3), 20, "t1_e_green");
    seg(on(Y, 2'd3), 5,  "t1_e_yellow");
    seg(red(2'd3),   2,  "t1_e_allred");
    step(on(G, 2'd0),    "t1_s_green_wrap");

    // Pedestrian pulse during S green. A second press during WALK is ignored.
    do_reset("t2");
    step(on(G, 2'd0), "t2_s_green");
    ped_req = 1'b1;
    step(on(G, 2'd0), "t2_s_green_req");
    ped_req = 1'b0;
    seg(on(G, 2'd0), 18, "t2_s_green");
    seg(on(Y, 2'd0), 5,  "t2_s_yellow");
    seg(red(2'd0),   2,  "t2_allred");
    seg(wlk(2'd0),   3,  "t2_walk");
    ped_req = 1'b1;
    step(wlk(2'd0),      "t2_walk_req");
    ped_req = 1'b0;
    seg(wlk(2'd0),   6,  "t2_walk");
    seg(on(G, 2'd1), 20, "t2_w_green");
    seg(on(Y, 2'd1), 5,  "t2_w_yellow");
    seg(red(2'd1),   2,  "t2_w_allred");
    step(on(G, 2'd2),    "t2_n_green_nowalk");

    // en=0 for 7 cycles mid green stretches it to 27 cycles. A request made
    // while frozen is still served.
    do_reset("t3");
    seg(on(G, 2'd0), 5,  "t3_s_green");
    en = 1'b0; ped_req = 1'b1;
    step(on(G, 2'd0),    "t3_frozen_req");
    ped_req = 1'b0;
    seg(on(G, 2'd0), 6,  "t3_frozen");
    en = 1'b1;
    seg(on(G, 2'd0), 15, "t3_s_green");
    seg(on(Y, 2'd0), 5,  "t3_s_yellow");
    seg(red(2'd0),   2,  "t3_allred");
    seg(wlk(2'd0),   10, "t3_walk");
    step(on(G, 2'd1),    "t3_w_green");

    // Night mode entered mid yellow, blinks, then exits through all-red to S.
    do_reset("t4");
    seg(on(G, 2'd0), 20, "t4_s_green");
    seg(on(Y, 2'd0), 2,  "t4_s_yellow");
    flash_mode = 1'b1;
    seg(fl(Y, 2'd0), 4,  "t4_flash_on");
    seg(fl(DK, 2'd0), 4, "t4_flash_off");
    seg(fl(Y, 2'd0), 4,  "t4_flash_on2");
    seg(fl(DK, 2'd0), 2, "t4_flash_off2");
    flash_mode = 1'b0;
    seg(red(2'd3),   2,  "t4_exit_allred");
    step(on(G, 2'd0),    "t4_s_green");

    // Reset mid WALK, with ped_req and flash_mode also raised. Reset wins,
    // and no walk follows the release.
    do_reset("t5");
    step(on(G, 2'd0), "t5_s_green");
    ped_req = 1'b1;
    step(on(G, 2'd0), "t5_s_green_req");
    ped_req = 1'b0;
    seg(on(G, 2'd0), 18, "t5_s_green");
    seg(on(Y, 2'd0), 5,  "t5_s_yellow");
    seg(red(2'd0),   2,  "t5_allred");
    seg(wlk(2'd0),   3,  "t5_walk");
    rst = 1'b1; ped_req = 1'b1; flash_mode = 1'b1;
    step(red(2'd3),      "t5_rst_mid_walk");
    rst = 1'b0; ped_req = 1'b0; flash_mode = 1'b0; en = 1'b1;
    step(red(2'd3),      "t5_rel_allred");
    seg(on(G, 2'd0), 20, "t5_s_green");
    seg(on(Y, 2'd0), 5,  "t5_s_yellow");
    seg(red(2'd0),   2,  "t5_allred");
    step(on(G, 2'd1),    "t5_w_green_nowalk");

    stim_done = 1'b1;
  end

endmodule
